// File: rtl/softmax_frame_rx.sv
// softmax_frame_rx: captures one softmax frame (N_CLASS posteriors), tracks argmax/max/sum,
// and offers the result downstream on a valid/ready handshake.
//   clk, rst_n             clock, asynchronous active-low reset
//   dv_in, din             posterior burst from the softmax stage
//   frame_valid/ready      result handshake toward the decoder
//   max_idx/max_val/sum_val frame result, stable while frame_valid=1
//   rd_addr, rd_data       registered random-access read of the frame buffer
//   busy                   engine not idle
//   len_err, ovr_err       single-cycle error pulses (bad length / burst dropped while held)
module softmax_frame_rx #(
  parameter int unsigned N_CLASS = 13,
  parameter int unsigned DW      = 11,
  parameter int unsigned IDX_W   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                dv_in,
  input  logic [DW-1:0]       din,
  output logic                frame_valid,
  input  logic                frame_ready,
  output logic [IDX_W-1:0]    max_idx,
  output logic [DW-1:0]       max_val,
  output logic [DW+IDX_W-1:0] sum_val,
  input  logic [IDX_W-1:0]    rd_addr,
  output logic [DW-1:0]       rd_data,
  output logic                busy,
  output logic                len_err,
  output logic                ovr_err
);

  // count needs one extra bit so the overlong marker N_CLASS+1 always fits
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned SW    = DW + IDX_W;
  localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N_CLASS);
  localparam logic [CNT_W-1:0] N_OVR = CNT_W'(N_CLASS + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] HOLD    = 2'd2;
  localparam logic [1:0] DROP    = 2'd3;

  logic [1:0]       state, state_d;
  logic [CNT_W-1:0] count, count_d;
  logic [IDX_W-1:0] max_idx_d;
  logic [DW-1:0]    max_val_d;
  logic [SW-1:0]    sum_d;
  logic             len_err_d, ovr_err_d;
  logic             ovr_seen, ovr_seen_d;
  logic             wr_en;
  logic [IDX_W-1:0] wr_addr;

  logic [DW-1:0] buf_mem [N_CLASS];

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      max_idx     <= '0;
      max_val     <= '0;
      sum_val     <= '0;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
      len_err     <= 1'b0;
      ovr_err     <= 1'b0;
      ovr_seen    <= 1'b0;
    end else begin
      state       <= state_d;
      count       <= count_d;
      max_idx     <= max_idx_d;
      max_val     <= max_val_d;
      sum_val     <= sum_d;
      frame_valid <= (state_d == HOLD);
      busy        <= (state_d != IDLE);
      len_err     <= len_err_d;
      ovr_err     <= ovr_err_d;
      ovr_seen    <= ovr_seen_d;
    end
  end

  // Next-state, accumulators and buffer write control
  always_comb begin
    state_d    = state;
    count_d    = count;
    max_idx_d  = max_idx;
    max_val_d  = max_val;
    sum_d      = sum_val;
    len_err_d  = 1'b0;
    ovr_err_d  = 1'b0;
    // ovr_seen marks a burst that already raised ovr_err; it ends with the burst
    ovr_seen_d = ovr_seen & dv_in;
    wr_en      = 1'b0;
    wr_addr    = IDX_W'(count);

    case (state)
      IDLE: begin
        if (dv_in) begin
          wr_en     = 1'b1;
          wr_addr   = '0;
          count_d   = CNT_W'(1);
          max_val_d = din;
          max_idx_d = '0;
          sum_d     = SW'(din);
          state_d   = CAPTURE;
        end
      end

      CAPTURE: begin
        if (dv_in) begin
          if (count < N_CNT) begin
            wr_en   = 1'b1;
            sum_d   = sum_val + SW'(din);
            count_d = count + CNT_W'(1);
            // strict compare keeps the lowest index on ties
            if (din > max_val) begin
              max_val_d = din;
              max_idx_d = IDX_W'(count);
            end
          end else begin
            count_d = N_OVR;
          end
        end else begin
          count_d = '0;
          if (count == N_CNT) begin
            state_d = HOLD;
          end else begin
            len_err_d = 1'b1;
            max_idx_d = '0;
            max_val_d = '0;
            sum_d     = '0;
            state_d   = IDLE;
          end
        end
      end

      HOLD: begin
        if (dv_in && !ovr_seen) begin
          ovr_err_d  = 1'b1;
          ovr_seen_d = 1'b1;
        end
        // a burst still running at accept time is drained in DROP
        if (frame_ready) state_d = dv_in ? DROP : IDLE;
      end

      DROP: begin
        if (!dv_in) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Frame buffer: no reset, contents undefined until written
  always_ff @(posedge clk) begin
    if (wr_en) buf_mem[wr_addr] <= din;
  end

  // Registered read port; same-cycle write returns the previous word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if ({1'b0, rd_addr} < N_CNT) begin
      rd_data <= buf_mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: tb/tb_softmax_frame_rx.sv
// Directed testbench for softmax_frame_rx.
module tb_softmax_frame_rx;

  localparam int N_CLASS = 13;
  localparam int DW      = 11;
  localparam int IDX_W   = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                dv_in;
  logic [DW-1:0]       din;
  logic                frame_valid;
  logic                frame_ready;
  logic [IDX_W-1:0]    max_idx;
  logic [DW-1:0]       max_val;
  logic [DW+IDX_W-1:0] sum_val;
  logic [IDX_W-1:0]    rd_addr;
  logic [DW-1:0]       rd_data;
  logic                busy;
  logic                len_err;
  logic                ovr_err;

  softmax_frame_rx #(.N_CLASS(N_CLASS), .DW(DW), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .dv_in(dv_in), .din(din),
    .frame_valid(frame_valid), .frame_ready(frame_ready),
    .max_idx(max_idx), .max_val(max_val), .sum_val(sum_val),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
    .len_err(len_err), .ovr_err(ovr_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int len_cnt = 0, ovr_cnt = 0, fv_cnt = 0, acc_cnt = 0;
  logic [DW-1:0] words [16];

  // Event counters sampled on the falling edge
  always @(negedge clk) begin
    if (len_err) len_cnt++;
    if (ovr_err) ovr_cnt++;
    if (frame_valid) fv_cnt++;
    if (frame_valid && frame_ready) acc_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_set(input int s);
    case (s)
      0: words = '{667, 286, 502, 846, 113, 454, 870, 568, 389, 408, 884, 763, 6, 999, 0, 0};
      1: for (int i = 0; i < 16; i++) words[i] = 11'd500;
      2: for (int i = 0; i < 16; i++) words[i] = DW'((i + 1) * 100);
      3: begin
        for (int i = 0; i < 16; i++) words[i] = 11'd100;
        words[3] = 11'd2047;
        words[7] = 11'd2047;
      end
      default: for (int i = 0; i < 16; i++) words[i] = 11'd2000;
    endcase
  endtask

  task automatic drive_burst(input int n);
    for (int i = 0; i < n; i++) begin
      dv_in = 1'b1;
      din   = words[i];
      tick();
    end
    dv_in = 1'b0;
    din   = '0;
  endtask

  task automatic accept();
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; dv_in = 1'b0; din = '0; frame_ready = 1'b0; rd_addr = '0;
    tick(); tick();
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_frame_valid got %0d exp 0", frame_valid); end
    checks++; if ({max_idx, max_val, sum_val, rd_data} !== '0) begin errors++; $display("FAIL reset_results got idx=%0d val=%0d sum=%0d rd=%0d exp 0", max_idx, max_val, sum_val, rd_data); end
    checks++; if ({busy, len_err, ovr_err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {busy, len_err, ovr_err}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_frame();
    load_set(0);
    drive_burst(13);
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_early got %0d exp 0", frame_valid); end
    tick();
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL basic_valid_latency got %0d exp 1", frame_valid); end
    checks++; if (max_idx !== 4'd10) begin errors++; $display("FAIL basic_max_idx got %0d exp 10", max_idx); end
    checks++; if (max_val !== 11'd884) begin errors++; $display("FAIL basic_max_val got %0d exp 884", max_val); end
    checks++; if (sum_val !== 15'd6756) begin errors++; $display("FAIL basic_sum got %0d exp 6756", sum_val); end
    for (int a = 0; a < 13; a++) begin
      rd_addr = IDX_W'(a);
      tick();
      checks++; if (rd_data !== words[a]) begin errors++; $display("FAIL basic_read addr=%0d got %0d exp %0d", a, rd_data, words[a]); end
    end
    rd_addr = 4'd13;
    tick();
    checks++; if (rd_data !== 11'd0) begin errors++; $display("FAIL basic_read_oob got %0d exp 0", rd_data); end
    accept();
    checks++; if ({frame_valid, busy} !== 2'b00) begin errors++; $display("FAIL basic_after_accept got %b exp 00", {frame_valid, busy}); end
  endtask

  task automatic test_hold_overrun();
    int ovr0;
    load_set(0);
    drive_burst(13);
    tick();
    ovr0 = ovr_cnt;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++; if ({frame_valid, max_idx, max_val, sum_val} !== {1'b1, 4'd10, 11'd884, 15'd6756}) begin errors++; $display("FAIL hold_stable cyc=%0d got v=%0d idx=%0d val=%0d sum=%0d", c, frame_valid, max_idx, max_val, sum_val); end
    end
    load_set(4);
    dv_in = 1'b1; din = words[0];
    tick();
    checks++; if (ovr_err !== 1'b1) begin errors++; $display("FAIL hold_ovr_pulse got %0d exp 1", ovr_err); end
    drive_burst(12);
    tick();
    checks++; if (ovr_cnt - ovr0 !== 1) begin errors++; $display("FAIL hold_ovr_count got %0d exp 1", ovr_cnt - ovr0); end
    checks++; if ({frame_valid, max_val, sum_val} !== {1'b1, 11'd884, 15'd6756}) begin errors++; $display("FAIL hold_after_drop got v=%0d val=%0d sum=%0d", frame_valid, max_val, sum_val); end
    rd_addr = 4'd3;
    tick();
    checks++; if (rd_data !== 11'd846) begin errors++; $display("FAIL hold_buffer_kept got %0d exp 846", rd_data); end
    accept();
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL hold_accept got %0d exp 0", frame_valid); end
    load_set(2);
    drive_burst(13);
    tick();
    checks++; if ({frame_valid, max_idx, max_val, sum_val} !== {1'b1, 4'd12, 11'd1300, 15'd9100}) begin errors++; $display("FAIL hold_next_frame got v=%0d idx=%0d val=%0d sum=%0d", frame_valid, max_idx, max_val, sum_val); end
    accept();
  endtask

  task automatic test_length_errors();
    int len0, fv0;
    len0 = len_cnt; fv0 = fv_cnt;
    load_set(0);
    drive_burst(12);
    tick();
    checks++; if (len_err !== 1'b1) begin errors++; $display("FAIL len_short_pulse got %0d exp 1", len_err); end
    checks++; if ({max_idx, max_val, sum_val} !== '0) begin errors++; $display("FAIL len_short_cleared got idx=%0d val=%0d sum=%0d exp 0", max_idx, max_val, sum_val); end
    tick();
    checks++; if ({len_err, busy} !== 2'b00) begin errors++; $display("FAIL len_short_after got %b exp 00", {len_err, busy}); end
    drive_burst(14);
    tick(); tick();
    checks++; if (len_cnt - len0 !== 2) begin errors++; $display("FAIL len_pulse_count got %0d exp 2", len_cnt - len0); end
    checks++; if (fv_cnt - fv0 !== 0) begin errors++; $display("FAIL len_no_valid got %0d exp 0", fv_cnt - fv0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL len_busy got %0d exp 0", busy); end
  endtask

  task automatic test_ties();
    load_set(1);
    drive_burst(13);
    tick();
    checks++; if ({max_idx, max_val, sum_val} !== {4'd0, 11'd500, 15'd6500}) begin errors++; $display("FAIL ties_equal got idx=%0d val=%0d sum=%0d exp 0/500/6500", max_idx, max_val, sum_val); end
    accept();
    load_set(3);
    drive_burst(13);
    tick();
    checks++; if ({max_idx, max_val, sum_val} !== {4'd3, 11'd2047, 15'd5194}) begin errors++; $display("FAIL ties_2047 got idx=%0d val=%0d sum=%0d exp 3/2047/5194", max_idx, max_val, sum_val); end
    accept();
  endtask

  task automatic test_reset_mid_frame();
    int len0, fv0;
    load_set(0);
    rd_addr = 4'd0;
    for (int i = 0; i < 5; i++) begin
      dv_in = 1'b1; din = words[i];
      tick();
    end
    din = words[5];
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({frame_valid, max_idx, max_val, sum_val, rd_data, busy, len_err, ovr_err} !== '0) begin errors++; $display("FAIL rst_async got idx=%0d val=%0d sum=%0d rd=%0d busy=%0d", max_idx, max_val, sum_val, rd_data, busy); end
    @(posedge clk); #1;
    din = words[6];
    tick();
    rst_n = 1'b1;
    len0 = len_cnt; fv0 = fv_cnt;
    for (int i = 7; i < 13; i++) begin
      din = words[i];
      tick();
    end
    dv_in = 1'b0; din = '0;
    tick(); tick();
    checks++; if (len_cnt - len0 !== 1) begin errors++; $display("FAIL rst_remainder_len got %0d exp 1", len_cnt - len0); end
    checks++; if (fv_cnt - fv0 !== 0) begin errors++; $display("FAIL rst_remainder_valid got %0d exp 0", fv_cnt - fv0); end
    drive_burst(13);
    tick();
    checks++; if ({frame_valid, max_idx, max_val, sum_val} !== {1'b1, 4'd10, 11'd884, 15'd6756}) begin errors++; $display("FAIL rst_next_frame got v=%0d idx=%0d val=%0d sum=%0d", frame_valid, max_idx, max_val, sum_val); end
    accept();
  endtask

  task automatic test_back_to_back();
    int ovr0, acc0;
    int e_idx [3] = '{10, 0, 12};
    int e_val [3] = '{884, 500, 1300};
    int e_sum [3] = '{6756, 6500, 9100};
    ovr0 = ovr_cnt; acc0 = acc_cnt;
    frame_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      load_set(f);
      drive_burst(13);
      // minimum gap: end-of-burst cycle then the accept cycle
      tick();
      checks++; if ({frame_valid, max_idx, max_val, sum_val} !== {1'b1, IDX_W'(e_idx[f]), DW'(e_val[f]), 15'(e_sum[f])}) begin errors++; $display("FAIL b2b_frame%0d got v=%0d idx=%0d val=%0d sum=%0d exp %0d/%0d/%0d", f, frame_valid, max_idx, max_val, sum_val, e_idx[f], e_val[f], e_sum[f]); end
      tick();
    end
    frame_ready = 1'b0;
    tick();
    checks++; if (acc_cnt - acc0 !== 3) begin errors++; $display("FAIL b2b_accepts got %0d exp 3", acc_cnt - acc0); end
    checks++; if (ovr_cnt - ovr0 !== 0) begin errors++; $display("FAIL b2b_no_ovr got %0d exp 0", ovr_cnt - ovr0); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_hold_overrun();
    test_length_errors();
    test_ties();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
